// File: rtl/cpu_pkg.sv
// Shared constants and types for the integer register file.
package cpu_pkg;

    localparam int REG_COUNT      = 32;
    localparam int REG_ADDR_W     = 5;
    localparam int ZERO_REG       = 31;
    localparam int DATA_WIDTH_DEF = 64;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // True when the index names the hard-wired zero register.
    function automatic logic is_zero_reg(input reg_addr_t addr);
        return addr == REG_ADDR_W'(ZERO_REG);
    endfunction

endpackage

// File: rtl/register_file_if.sv
// Bundle of register-file write and read signals; master drives addresses/data.
interface register_file_if
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic                  write_en;
    reg_addr_t             write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    reg_addr_t             read_addr_a;
    reg_addr_t             read_addr_b;
    logic [DATA_WIDTH-1:0] read_data_a;
    logic [DATA_WIDTH-1:0] read_data_b;

    modport master (
        output write_en,
        output write_addr,
        output write_data,
        output read_addr_a,
        output read_addr_b,
        input  read_data_a,
        input  read_data_b
    );

    modport slave (
        input  write_en,
        input  write_addr,
        input  write_data,
        input  read_addr_a,
        input  read_addr_b,
        output read_data_a,
        output read_data_b
    );

endinterface

// File: rtl/decoder_5x32.sv
// One-hot 5-to-32 write-select decoder, all outputs low when en is low.
module decoder_5x32
    import cpu_pkg::*;
(
    input  logic                 en,
    input  reg_addr_t            addr,
    output logic [REG_COUNT-1:0] onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < REG_COUNT; gi++) begin : g_dec
            assign onehot[gi] = en && (addr == REG_ADDR_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/dff_en.sv
// Enabled D flip-flop: a 2:1 mux feeds back q when en is low.
module dff_en #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;

    mux2 #(.WIDTH(WIDTH)) u_hold (
        .d0  (q_reg),
        .d1  (d),
        .sel (en),
        .y   (q_next)
    );

    // Capture the hold-mux output; reset clears regardless of en.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/mux2.sv
// 2:1 multiplexer primitive; sel=1 picks d1.
module mux2 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/register_file.sv
// 32 x DATA_WIDTH register file, X31 reads as zero, two combinational read
// ports built from 2:1 mux trees, optional same-cycle write forwarding.
module register_file
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BYPASS     = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  write_en_i,
    input  logic [REG_ADDR_W-1:0] write_addr_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    input  logic [REG_ADDR_W-1:0] read_addr_a_i,
    input  logic [REG_ADDR_W-1:0] read_addr_b_i,
    output logic [DATA_WIDTH-1:0] read_data_a_o,
    output logic [DATA_WIDTH-1:0] read_data_b_o
);

    logic [REG_COUNT-1:0]  write_sel;
    logic                  unused_zero_sel;
    logic [DATA_WIDTH-1:0] reg_q  [ZERO_REG];

    // Mux tree levels, leaves first; each level halves and consumes one address bit.
    logic [DATA_WIDTH-1:0] leaf_a [32];
    logic [DATA_WIDTH-1:0] leaf_b [32];
    logic [DATA_WIDTH-1:0] lvl4_a [16];
    logic [DATA_WIDTH-1:0] lvl4_b [16];
    logic [DATA_WIDTH-1:0] lvl3_a [8];
    logic [DATA_WIDTH-1:0] lvl3_b [8];
    logic [DATA_WIDTH-1:0] lvl2_a [4];
    logic [DATA_WIDTH-1:0] lvl2_b [4];
    logic [DATA_WIDTH-1:0] lvl1_a [2];
    logic [DATA_WIDTH-1:0] lvl1_b [2];
    logic [DATA_WIDTH-1:0] root_a;
    logic [DATA_WIDTH-1:0] root_b;

    logic                  fwd_ok;

    decoder_5x32 u_dec (
        .en     (write_en_i),
        .addr   (write_addr_i),
        .onehot (write_sel)
    );

    // X31 has no storage, so its select line goes nowhere.
    assign unused_zero_sel = write_sel[ZERO_REG];

    genvar gi;
    generate
        // Storage for X0..X30; X31 is a constant-zero leaf.
        for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
            if (gi == ZERO_REG) begin : g_zero
                assign leaf_a[gi] = '0;
                assign leaf_b[gi] = '0;
            end else begin : g_store
                dff_en #(.WIDTH(DATA_WIDTH)) u_cell (
                    .clk   (clk_i),
                    .reset (reset_i),
                    .en    (write_sel[gi]),
                    .d     (write_data_i),
                    .q     (reg_q[gi])
                );
                assign leaf_a[gi] = reg_q[gi];
                assign leaf_b[gi] = reg_q[gi];
            end
        end

        // Address bit 0 picks between neighbouring registers.
        for (gi = 0; gi < 16; gi++) begin : g_lvl4
            mux2 #(.WIDTH(DATA_WIDTH)) u_a (.d0(leaf_a[2*gi]), .d1(leaf_a[2*gi+1]),
                                            .sel(read_addr_a_i[0]), .y(lvl4_a[gi]));
            mux2 #(.WIDTH(DATA_WIDTH)) u_b (.d0(leaf_b[2*gi]), .d1(leaf_b[2*gi+1]),
                                            .sel(read_addr_b_i[0]), .y(lvl4_b[gi]));
        end

        for (gi = 0; gi < 8; gi++) begin : g_lvl3
            mux2 #(.WIDTH(DATA_WIDTH)) u_a (.d0(lvl4_a[2*gi]), .d1(lvl4_a[2*gi+1]),
                                            .sel(read_addr_a_i[1]), .y(lvl3_a[gi]));
            mux2 #(.WIDTH(DATA_WIDTH)) u_b (.d0(lvl4_b[2*gi]), .d1(lvl4_b[2*gi+1]),
                                            .sel(read_addr_b_i[1]), .y(lvl3_b[gi]));
        end

        for (gi = 0; gi < 4; gi++) begin : g_lvl2
            mux2 #(.WIDTH(DATA_WIDTH)) u_a (.d0(lvl3_a[2*gi]), .d1(lvl3_a[2*gi+1]),
                                            .sel(read_addr_a_i[2]), .y(lvl2_a[gi]));
            mux2 #(.WIDTH(DATA_WIDTH)) u_b (.d0(lvl3_b[2*gi]), .d1(lvl3_b[2*gi+1]),
                                            .sel(read_addr_b_i[2]), .y(lvl2_b[gi]));
        end

        for (gi = 0; gi < 2; gi++) begin : g_lvl1
            mux2 #(.WIDTH(DATA_WIDTH)) u_a (.d0(lvl2_a[2*gi]), .d1(lvl2_a[2*gi+1]),
                                            .sel(read_addr_a_i[3]), .y(lvl1_a[gi]));
            mux2 #(.WIDTH(DATA_WIDTH)) u_b (.d0(lvl2_b[2*gi]), .d1(lvl2_b[2*gi+1]),
                                            .sel(read_addr_b_i[3]), .y(lvl1_b[gi]));
        end
    endgenerate

    // Address bit 4 makes the final choice at the root.
    mux2 #(.WIDTH(DATA_WIDTH)) u_root_a (.d0(lvl1_a[0]), .d1(lvl1_a[1]),
                                         .sel(read_addr_a_i[4]), .y(root_a));
    mux2 #(.WIDTH(DATA_WIDTH)) u_root_b (.d0(lvl1_b[0]), .d1(lvl1_b[1]),
                                         .sel(read_addr_b_i[4]), .y(root_b));

    // Forwarding is allowed only for a real write that reset is not about to discard.
    always_comb begin
        fwd_ok = (BYPASS != 0) && !reset_i && write_en_i && !is_zero_reg(write_addr_i);
    end

    // Read ports: stored value, overridden by in-flight write data on an address match.
    always_comb begin
        read_data_a_o = root_a;
        read_data_b_o = root_b;
        if (fwd_ok && (read_addr_a_i == write_addr_i)) begin
            read_data_a_o = write_data_i;
        end
        if (fwd_ok && (read_addr_b_i == write_addr_i)) begin
            read_data_b_o = write_data_i;
        end
    end

endmodule
